// File: rtl/graph_pkg.sv
// graph_pkg -- shared constants and types for the graph pipeline.
//   PRECISION    : bits per node feature
//   EDGE_BITS    : low-order edge/flag bits in every node word
//   IS_EVENT_BIT : edge bit that marks a node as carrying an event
//   NUM_BANKS    : number of rotating node-memory banks
package graph_pkg;

  localparam int PRECISION    = 8;
  localparam int EDGE_BITS    = 18;
  localparam int IS_EVENT_BIT = 4;
  localparam int NUM_BANKS    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    CLEAR = 2'd3
  } scan_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo -- show-ahead synchronous FIFO, power-of-two depth.
//   clk, reset (async, active-low)
//   push/din  : write side; a push while full is accepted only with a pop
//   pop/dout  : read side; dout shows the head entry whenever !empty
//   empty, full, count : occupancy status
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_reg;
  logic [PTR_W-1:0]       rd_ptr_reg;
  logic [$clog2(DEPTH):0] count_reg;
  logic                   do_push;
  logic                   do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == ($clog2(DEPTH) + 1)'(DEPTH));
  assign count   = count_reg;
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/graph_bank_scanner.sv
// graph_bank_scanner -- when the pooling stage moves to a new bank, sweep the
// bank it just left: stream every event node to the next layer, then zero it.
//   clk, reset (async, active-low)
//   bank_ptr            : bank currently written by pooling (0..2)
//   read                : BRAM read data, valid READ_LATENCY cycles after ena
//   addr/ena/wea/write  : BRAM port (write data is always zero)
//   rd_bank             : bank being scanned or cleared
//   out_valid/out_ready/out_addr/out_data : event node stream
//   busy                : sweep in progress (SCAN through CLEAR)
//   overrun             : sticky, bank_ptr moved while a sweep was running
module graph_bank_scanner
  import graph_pkg::*;
#(
  parameter int GRAPH_SIZE   = 16,
  parameter int PRECISION    = graph_pkg::PRECISION,
  parameter int INPUT_DIM    = 32,
  parameter int ADDR_WIDTH   = $clog2(GRAPH_SIZE*GRAPH_SIZE),
  parameter int DATA_WIDTH   = INPUT_DIM*PRECISION+18,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            bank_ptr,
  input  logic [DATA_WIDTH-1:0] read,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  ena,
  output logic                  wea,
  output logic [DATA_WIDTH-1:0] write,
  output logic [1:0]            rd_bank,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  overrun
);

  localparam int N      = GRAPH_SIZE * GRAPH_SIZE;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int FW     = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);

  scan_state_t           state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [1:0]            rd_bank_reg, rd_bank_next;
  logic [1:0]            bank_prev_reg;
  logic                  bank_seen_reg;
  logic                  overrun_reg;
  logic                  bank_change;
  logic                  trigger;

  logic [READ_LATENCY-1:0] vld_pipe_reg;
  logic [ADDR_WIDTH-1:0]   addr_pipe_reg [READ_LATENCY];
  int                      in_flight;
  int                      free_slots;
  logic                    credit_ok;
  logic                    issue;

  logic             fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [FW-1:0]    fifo_dout;
  logic [CNT_W-1:0] fifo_count;

  // bank_seen_reg keeps the first clock after reset from looking like a change.
  assign bank_change = bank_seen_reg && (bank_prev_reg != bank_ptr);
  assign trigger     = bank_change && (state_reg == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_prev_reg <= '0;
      bank_seen_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      bank_prev_reg <= bank_ptr;
      bank_seen_reg <= 1'b1;
      if (bank_change && (state_reg != IDLE)) overrun_reg <= 1'b1;
    end
  end

  // Read-return pipeline: valid bit and address travel with each read.
  generate
    for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_pipe
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) vld_pipe_reg[gi] <= 1'b0;
        else        vld_pipe_reg[gi] <= (gi == 0) ? issue : vld_pipe_reg[(gi == 0) ? 0 : gi-1];
      end
      always_ff @(posedge clk) begin
        addr_pipe_reg[gi] <= (gi == 0) ? addr_reg : addr_pipe_reg[(gi == 0) ? 0 : gi-1];
      end
    end
  endgenerate

  always_comb begin
    in_flight = 0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      in_flight = in_flight + int'(vld_pipe_reg[i]);
    end
  end

  // Credit rule: a read may only issue if a slot is reserved for every
  // outstanding read, so the FIFO can never overflow.
  assign free_slots = FIFO_DEPTH - int'(fifo_count);
  assign credit_ok  = free_slots > in_flight;
  assign issue      = (state_reg == SCAN) && credit_ok;

  assign fifo_push = vld_pipe_reg[READ_LATENCY-1] && read[IS_EVENT_BIT];
  assign fifo_pop  = out_valid && out_ready;

  sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({addr_pipe_reg[READ_LATENCY-1], read}),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      rd_bank_reg <= '0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      rd_bank_reg <= rd_bank_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    rd_bank_next = rd_bank_reg;
    ena          = 1'b0;
    wea          = 1'b0;
    unique case (state_reg)
      IDLE: begin
        addr_next = '0;
        if (trigger) begin
          state_next   = SCAN;
          rd_bank_next = bank_prev_reg;
        end
      end
      SCAN: begin
        if (credit_ok) begin
          ena = 1'b1;
          if (addr_reg == LAST_ADDR) begin
            addr_next  = '0;
            state_next = DRAIN;
          end else begin
            addr_next = addr_reg + 1'b1;
          end
        end
      end
      DRAIN: begin
        if ((in_flight == 0) && fifo_empty) state_next = CLEAR;
      end
      CLEAR: begin
        ena = 1'b1;
        wea = 1'b1;
        if (addr_reg == LAST_ADDR) begin
          addr_next  = '0;
          state_next = IDLE;
        end else begin
          addr_next = addr_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign addr      = addr_reg;
  assign rd_bank   = rd_bank_reg;
  assign write     = '0;
  assign busy      = (state_reg != IDLE);
  assign overrun   = overrun_reg;
  assign out_valid = !fifo_empty;
  assign {out_addr, out_data} = fifo_dout;

endmodule

// File: doc/graph_bank_scanner.md
GRAPH_BANK_SCANNER -- requirements
Module: graph_bank_scanner

Interface
REQ-001 SHALL have parameter GRAPH_SIZE, default 16, giving the side of the pooled graph (GRAPH_SIZE*GRAPH_SIZE nodes).
REQ-002 SHALL have parameter PRECISION, default graph_pkg::PRECISION, giving the bits per feature.
REQ-003 SHALL have parameter INPUT_DIM, default 32, giving the features per node.
REQ-004 SHALL have parameter ADDR_WIDTH, default $clog2(GRAPH_SIZE*GRAPH_SIZE), giving the node address width.
REQ-005 SHALL have parameter DATA_WIDTH, default INPUT_DIM*PRECISION+18, giving the node word (features above 18 edge bits).
REQ-006 SHALL have parameter READ_LATENCY, default 2, giving the BRAM ena-to-data cycles.
REQ-007 SHALL have parameter FIFO_DEPTH, default 4, giving the output buffer entries (power of 2).
REQ-008 SHALL have port clk, input, 1, the single clock.
REQ-009 SHALL have port reset, input, 1, reset: asynchronous, active-low.
REQ-010 SHALL have port bank_ptr, input, 2, the bank the pooling stage currently writes (0..2).
REQ-011 SHALL have port read, input, DATA_WIDTH, the BRAM read data.
REQ-012 SHALL have port addr, output, ADDR_WIDTH, the BRAM address.
REQ-013 SHALL have port ena, output, 1, the BRAM enable.
REQ-014 SHALL have port wea, output, 1, the BRAM write enable.
REQ-015 SHALL have port write, output, DATA_WIDTH, the BRAM write data, always zero.
REQ-016 SHALL have port rd_bank, output, 2, the bank being scanned or cleared.
REQ-017 SHALL have port out_valid, input out_ready, output out_addr (ADDR_WIDTH) and output out_data (DATA_WIDTH), forming the node stream to the next layer.
REQ-018 SHALL have port busy, output, 1, high from the start of SCAN until the end of CLEAR.
REQ-019 SHALL have port overrun, output, 1, a sticky error flag.

Function
REQ-020 SHALL register bank_ptr every cycle; a change (prev != current) while in IDLE is a trigger at cycle t.
REQ-021 On a trigger, SHALL set rd_bank to the previous bank_ptr value (2->0 wrap gives rd_bank=2) and enter SCAN at t+1.
REQ-022 FSM states SHALL be IDLE, SCAN, DRAIN and CLEAR: IDLE->SCAN on trigger; SCAN->DRAIN after the read of the last address is issued; DRAIN->CLEAR when in-flight=0 and FIFO empty; CLEAR->IDLE after the last zero write.
REQ-023 In SCAN, SHALL issue one read per cycle (ena=1, wea=0, addr 0..N-1 ascending) only while free FIFO slots exceed the in-flight reads; otherwise hold addr with ena=0.
REQ-024 Read data SHALL be captured READ_LATENCY cycles after its ena, with its address carried in a matching shift register.
REQ-025 A captured word with edge bit graph_pkg::IS_EVENT_BIT (bit 4) set SHALL be pushed as {addr, word}; words with bit 4 clear SHALL be discarded.
REQ-026 out_valid SHALL be high when the FIFO is non-empty; a pop SHALL occur on out_valid&&out_ready; out_addr/out_data SHALL hold stable while out_valid&&!out_ready.
REQ-027 The FIFO SHALL never overflow (guaranteed by the credit rule); a simultaneous push and pop on a full FIFO SHALL be legal.
REQ-028 In CLEAR, SHALL assert ena=1, wea=1 and write=0 for addr 0..N-1 on consecutive cycles, unconditionally.
REQ-029 In IDLE, ena and wea SHALL be 0 and addr SHALL be 0.
REQ-030 A bank_ptr change outside IDLE SHALL set overrun=1 (held until reset) and SHALL NOT restart or extend the current sweep.
REQ-031 Best-case sweep duration SHALL be N + READ_LATENCY + 1 (drain) + N cycles.

Reset
REQ-032 On reset low, SHALL asynchronously force FSM=IDLE, out_valid=0, busy=0, overrun=0, ena=0, wea=0, addr=0, rd_bank=0, FIFO empty and in-flight=0, and SHALL load the registered bank_ptr from the input on the first clock after release.
REQ-033 Reset mid-sweep SHALL abandon the sweep; the memory SHALL NOT be cleared and no trigger SHALL result from release.

Structure
REQ-034 IS_EVENT_BIT=4, EDGE_BITS=18, NUM_BANKS=3 and PRECISION SHALL reside in graph_pkg.
REQ-035 The output buffer SHALL be one sub-module, sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, empty, full, count).

Verification (GRAPH_SIZE=4, READ_LATENCY=2, FIFO_DEPTH=4)
REQ-036 Scenario: bank_ptr 0->1 with addresses 3 and 10 having bit4=1 and out_ready=1 -> rd_bank=0, beats out_addr=3 then 10, then 16 zero writes, busy low after CLEAR.
REQ-037 Scenario: all bit4=1 and out_ready=0 -> exactly 4 reads issued then ena=0; releasing out_ready yields 16 beats in address order with none lost.
REQ-038 Scenario: bank_ptr 1->2 at SCAN cycle 5 -> overrun=1, sweep of bank 1 completes unchanged, no second sweep.
REQ-039 Scenario: bank_ptr 2->0 with an empty bank -> rd_bank=2, no out_valid, 16 clear writes.
REQ-040 Scenario: reset asserted at SCAN cycle 7 -> all outputs zero immediately; after release no activity until the next bank_ptr change.
